// File: rtl/dft_pkg.sv
// Shared definitions for the radix-2 DFT stages: state encoding and counter-width helpers.
package dft_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        CALC  = 2'd1,
        DRAIN = 2'd2
    } dft_state_t;

    localparam int DFT_N_DEFAULT  = 32;
    localparam int DFT_IW_DEFAULT = 8;

    // Width of a counter that walks over half a frame.
    function automatic int dft_cnt_w(input int n);
        return (n / 2 > 1) ? $clog2(n / 2) : 1;
    endfunction

endpackage

// File: rtl/dft_but.sv
// Combinational radix-2 butterfly: sum and difference of two OW-bit signed operands.
module dft_but #(
    parameter int OW = 9
) (
    input  logic signed [OW-1:0] a,
    input  logic signed [OW-1:0] b,
    output logic signed [OW-1:0] sum,
    output logic signed [OW-1:0] diff
);

    assign sum  = a + b;
    assign diff = a - b;

endmodule

// File: rtl/dft_stage_r2.sv
// Radix-2 DFT first stage: fa_k = x[k]+x[k+N/2], fb_k = x[k]-x[k+N/2], streamed out fa then fb.
// Optional frame-start checking is enabled by defining DFT_STAGE_SOF_CHK_EN.
module dft_stage_r2
    import dft_pkg::*;
#(
    parameter  int N  = DFT_N_DEFAULT,
    parameter  int IW = DFT_IW_DEFAULT,
    localparam int OW = IW + 1,
    localparam int CW = dft_cnt_w(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IW-1:0]        in_data,
    input  logic                 in_sof,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data,
    output logic                 out_sel,
    output logic [CW-1:0]        out_idx,
    output logic                 frame_err
);

    localparam int            HALF = N / 2;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    dft_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, wr_addr;
    logic signed [OW-1:0] sbuf [HALF];
    logic signed [OW-1:0] x_ext, bcur, bsum, bdiff;
    logic advance, accept, wr_fill, wr_diff, load_fa, load_fb, flush, err_set;

    assign x_ext   = {in_data[IW-1], in_data};
    assign bcur    = sbuf[cnt];
    assign advance = !out_valid || out_ready;
    assign accept  = in_valid && in_ready;

    dft_but #(.OW(OW)) u_but (
        .a    (bcur),
        .b    (x_ext),
        .sum  (bsum),
        .diff (bdiff)
    );

    always_comb begin
        case (state)
            FILL:    in_ready = 1'b1;
            CALC:    in_ready = advance;
            default: in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_addr   = cnt;
        wr_fill   = 1'b0;
        wr_diff   = 1'b0;
        load_fa   = 1'b0;
        load_fb   = 1'b0;
        flush     = 1'b0;
        err_set   = 1'b0;
        case (state)
            FILL: if (accept) begin
                wr_fill = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = CALC;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            CALC: if (accept) begin
                load_fa = 1'b1;
                wr_diff = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DRAIN: if (advance) begin
                load_fb = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = FILL;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = FILL;
                cnt_nxt   = '0;
            end
        endcase
`ifdef DFT_STAGE_SOF_CHK_EN
        // A stray frame start restarts the frame at this sample; a missing one drops the sample.
        if (accept && in_sof && !(state == FILL && cnt == '0)) begin
            state_nxt = FILL;
            cnt_nxt   = CW'(1);
            wr_addr   = '0;
            wr_fill   = 1'b1;
            wr_diff   = 1'b0;
            load_fa   = 1'b0;
            flush     = 1'b1;
            err_set   = 1'b1;
        end else if (accept && !in_sof && state == FILL && cnt == '0) begin
            cnt_nxt = '0;
            wr_fill = 1'b0;
            err_set = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The half-frame buffer holds x[k] during FILL and x[k]-x[k+N/2] once CALC has passed it.
    always_ff @(posedge clk) begin
        if (wr_fill) begin
            sbuf[wr_addr] <= x_ext;
        end else if (wr_diff) begin
            sbuf[cnt] <= bdiff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 1'b0;
            out_idx   <= '0;
        end else if (load_fa) begin
            out_valid <= 1'b1;
            out_data  <= bsum;
            out_sel   <= 1'b0;
            out_idx   <= cnt;
        end else if (load_fb) begin
            out_valid <= 1'b1;
            out_data  <= bcur;
            out_sel   <= 1'b1;
            out_idx   <= cnt;
        end else if (flush || advance) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DFT_STAGE_SOF_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else if (err_set) begin
            frame_err <= 1'b1;
        end
    end
`else
    logic unused_sof;
    assign unused_sof = in_sof ^ err_set;
    assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_dft_stage_r2.sv
// Self-checking bench for dft_stage_r2 (N=32, IW=8) with a queue-based reference model.
module tb_dft_stage_r2;

    localparam int N    = 32;
    localparam int IW   = 8;
    localparam int OW   = 9;
    localparam int CW   = 4;
    localparam int HALF = 16;

    typedef struct {
        int data;
        int sel;
        int idx;
    } exp_t;
    typedef int frame_t [N];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic          in_sof = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] out_data;
    logic          out_sel;
    logic [CW-1:0] out_idx;
    logic          frame_err;

    int   nvec = 0;
    int   nerr = 0;
    exp_t expq [$];
    exp_t e;
    int   cur [$];
    int   got [$];
    bit   model_err = 1'b0;
    bit   rand_ready = 1'b0;
    int   busy_cnt = 0;
    bit   held_prev = 1'b0;
    int   prev_word = 0;

    always #5 clk = ~clk;

    dft_stage_r2 #(.N(N), .IW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_idx   (out_idx),
        .frame_err (frame_err)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        nvec++;
        if (actual != expected) begin
            nerr++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: fa_k is known once x[k+N/2] arrives, all fb_k once the frame is complete.
    task automatic modelAccept(input int x, input bit sof);
`ifdef DFT_STAGE_SOF_CHK_EN
        if (sof && cur.size() != 0) begin
            model_err = 1'b1;
            expq.delete();
            cur.delete();
            cur.push_back(x);
            return;
        end
        if (!sof && cur.size() == 0) begin
            model_err = 1'b1;
            return;
        end
`endif
        cur.push_back(x);
        if (cur.size() > HALF) begin
            int k;
            k = cur.size() - HALF - 1;
            expq.push_back('{cur[k] + cur[k + HALF], 0, k});
        end
        if (cur.size() == N) begin
            for (int k = 0; k < HALF; k++) expq.push_back('{cur[k] - cur[k + HALF], 1, k});
            cur.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            cur.delete();
            model_err = 1'b0;
            held_prev = 1'b0;
        end else begin
            if (!in_ready) busy_cnt++;
            if (out_valid) begin
                if (held_prev) checkOutput("stall_hold", int'({out_sel, out_idx, out_data}), prev_word);
                if (out_ready) begin
                    if (expq.size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("[TB] FAIL unexpected_out: got %0d, expected no output", int'($signed(out_data)));
                    end else begin
                        e = expq.pop_front();
                        checkOutput("out_data", int'($signed(out_data)), e.data);
                        checkOutput("out_sel", int'(out_sel), e.sel);
                        checkOutput("out_idx", int'(out_idx), e.idx);
                    end
                    got.push_back(int'($signed(out_data)));
                end
            end
            held_prev = out_valid && !out_ready;
            prev_word = int'({out_sel, out_idx, out_data});
            if (in_valid && in_ready) modelAccept(int'($signed(in_data)), in_sof);
            checkOutput("frame_err", int'(frame_err), int'(model_err));
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic setReady(input bit rnd);
        @(negedge clk);
        #2;
        rand_ready = rnd;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic sendSample(input int x, input bit sof);
        bit acc = 1'b0;
        int t = 0;
        in_data  = IW'(x);
        in_sof   = sof;
        in_valid = 1'b1;
        while (!acc && t < 1000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) begin
            nvec++;
            nerr++;
            $display("[TB] FAIL accept_timeout: got no accept, expected accept of %0d", x);
        end
    endtask

    task automatic applyStimulus(input frame_t frm, input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            sendSample(frm[i], i == 0);
        end
    endtask

    task automatic waitIdle();
        int t = 0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        while ((expq.size() != 0 || out_valid) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 2000) begin
            nvec++;
            nerr++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", expq.size());
        end
    endtask

    task automatic checkRamp(input string tag);
        checkOutput({tag, "_count"}, got.size(), N);
        for (int k = 0; k < N && k < got.size(); k++)
            checkOutput(tag, got[k], (k < HALF) ? (2 * k + 16) : -16);
    endtask

    task automatic runRamp(input bit lat_checks);
        got.delete();
        for (int i = 0; i < N; i++) begin
            sendSample(i, i == 0);
            if (lat_checks && i == HALF - 1) checkOutput("lat_pre_valid", int'(out_valid), 0);
            if (lat_checks && i == HALF) begin
                checkOutput("lat_valid", int'(out_valid), 1);
                checkOutput("lat_fa0", int'($signed(out_data)), 16);
            end
        end
        waitIdle();
    endtask

    initial begin
        frame_t frm;
        frame_t frm2;

        #2;
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_data", int'(out_data), 0);
        checkOutput("rst_in_ready", int'(in_ready), 1);
        checkOutput("rst_frame_err", int'(frame_err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] latency ramp");
        runRamp(1'b1);
        checkRamp("ramp");

        $display("[TB] extreme values");
        for (int i = 0; i < N; i++) frm[i] = (i < HALF) ? -128 : 127;
        got.delete();
        applyStimulus(frm, 1'b0);
        waitIdle();
        checkOutput("ext_count", got.size(), N);
        if (got.size() == N) begin
            checkOutput("ext_fa0", got[0], -1);
            checkOutput("ext_fa15", got[15], -1);
            checkOutput("ext_fb0", got[16], -255);
            checkOutput("ext_fb15", got[31], -255);
        end

        $display("[TB] backpressure");
        setReady(1'b1);
        runRamp(1'b0);
        setReady(1'b0);
        checkRamp("bp_ramp");

        $display("[TB] back-to-back frames");
        for (int i = 0; i < N; i++) begin
            frm[i]  = $signed(8'($urandom));
            frm2[i] = $signed(8'($urandom));
        end
        busy_cnt = 0;
        applyStimulus(frm, 1'b0);
        applyStimulus(frm2, 1'b0);
        waitIdle();
        checkOutput("drain_busy_cycles", busy_cnt, 2 * HALF);

        $display("[TB] reset during CALC");
        for (int i = 0; i < HALF + 5; i++) sendSample(i, i == 0);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", int'(out_valid), 0);
        checkOutput("mid_rst_data", int'(out_data), 0);
        checkOutput("mid_rst_sel", int'(out_sel), 0);
        checkOutput("mid_rst_idx", int'(out_idx), 0);
        checkOutput("mid_rst_ready", int'(in_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        runRamp(1'b1);
        checkRamp("post_rst_ramp");

        $display("[TB] random frames");
        setReady(1'b1);
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) frm[i] = $signed(8'($urandom));
            applyStimulus(frm, 1'b1);
        end
        waitIdle();
        setReady(1'b0);

`ifdef DFT_STAGE_SOF_CHK_EN
        $display("[TB] frame start resync");
        for (int i = 0; i < 7; i++) sendSample(i, i == 0);
        frm[0] = 100;
        for (int i = 1; i < N; i++) frm[i] = $signed(8'($urandom));
        got.delete();
        applyStimulus(frm, 1'b0);
        waitIdle();
        checkOutput("sof_frame_err", int'(frame_err), 1);
        checkOutput("sof_count", got.size(), N);
        if (got.size() == N) begin
            checkOutput("sof_fa0", got[0], 100 + frm[HALF]);
            checkOutput("sof_fb0", got[HALF], 100 - frm[HALF]);
        end
`else
        $display("[TB] stray frame start ignored");
        got.delete();
        for (int i = 0; i < N; i++) sendSample(i, i == 0 || i == 7);
        waitIdle();
        checkRamp("sof_ignored");
        checkOutput("sof_frame_err", int'(frame_err), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dft_stage_r2.md
DFT_STAGE_R2 -- requirements
Module: dft_stage_r2

Interface
REQ-001 SHALL have parameter N, default 32, meaning points per frame (power of two, 4..1024).
REQ-002 SHALL have parameter IW, default 8, meaning input sample width (signed); OW = IW+1 is the output width.
REQ-003 SHALL have one clock and one reset: clk  input  1  sole clock, rising edge; rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have in_valid  input  1  input sample valid.
REQ-005 SHALL have in_ready  output  1  stage accepts a sample this cycle.
REQ-006 SHALL have in_data  input  IW  signed real sample x[n].
REQ-007 SHALL have in_sof  input  1  marks x[0] of a frame.
REQ-008 SHALL have out_valid  output  1  output sample valid.
REQ-009 SHALL have out_ready  input  1  downstream accepts output.
REQ-010 SHALL have out_data  output  OW  signed result.
REQ-011 SHALL have out_sel  output  1  0 = fa (sum), 1 = fb (difference).
REQ-012 SHALL have out_idx  output  log2(N/2)  k of fa_k/fb_k.
REQ-013 SHALL have frame_err  output  1  sticky misalignment flag (REQ-032).

Function
REQ-014 SHALL compute fa_k = x[k] + x[k+N/2] and fb_k = x[k] - x[k+N/2], k = 0..N/2-1, full precision, sign-extended to OW; no overflow possible.
REQ-015 SHALL use states FILL, CALC, DRAIN and counter cnt (log2(N/2) bits).
REQ-016 FILL: each accepted sample written sign-extended to buf[cnt]; cnt increments; at cnt = N/2-1 go to CALC, cnt <= 0; no output produced.
REQ-017 CALC: each accepted sample x produces fa_cnt = buf[cnt] + x on the output register and buf[cnt] <= buf[cnt] - x; at cnt = N/2-1 go to DRAIN, cnt <= 0.
REQ-018 DRAIN: no input accepted; each output advance loads buf[cnt] as fb_cnt; at cnt = N/2-1 go to FILL, cnt <= 0.
REQ-019 advance = !out_valid || out_ready.
REQ-020 in_ready = 1 in FILL; = advance in CALC; = 0 in DRAIN.
REQ-021 Accept = in_valid && in_ready; the state machine moves only on accept (FILL, CALC) or advance (DRAIN).
REQ-022 Latency: fa_k appears on out_data exactly one cycle after the accept of x[k+N/2].
REQ-023 Output register holds data/sel/idx stable while out_valid && !out_ready.
REQ-024 out_valid clears on advance when no new result is loaded.
REQ-025 Output order per frame: fa_0..fa_{N/2-1}, then fb_0..fb_{N/2-1}, without gaps when out_ready = 1.
REQ-026 First FILL accept of the next frame is allowed in the same cycle the last fb is loaded.
REQ-027 in_sof is ignored unless DFT_STAGE_SOF_CHK_EN is defined.

Reset
REQ-028 rst_n low SHALL immediately force: state FILL, cnt 0, out_valid 0, out_data 0, out_sel 0, out_idx 0, frame_err 0; in_ready reads 1 after reset.
REQ-029 buf SHALL NOT be reset; its contents are always rewritten in FILL before use.
REQ-030 Reset mid-frame SHALL discard the partial frame; the next accepted sample is treated as x[0].

Configuration
REQ-031 Macro DFT_STAGE_SOF_CHK_EN SHALL control frame-start checking.
REQ-032 With the macro defined: an accepted sample with in_sof = 1 when not (FILL && cnt = 0) sets frame_err; the stage resyncs (state FILL, buf[0] <= sample, cnt <= 1); pending output is flushed (out_valid <= 0).
REQ-032a With the macro defined: an accept in FILL with cnt = 0 and in_sof = 0 is dropped and sets frame_err.
REQ-033 Without the macro: frame_err is tied to 0 and in_sof is unused.

Structure
REQ-034 Package dft_pkg SHALL hold the state enum (FILL/CALC/DRAIN) and the clog2-based width constants shared with other dft stages.
REQ-035 Sub-module dft_but SHALL hold the combinational OW-bit add/subtract pair; state, counter, buffer and output register live in dft_stage_r2.

Verification
REQ-036 Check the latency scenario: N=32, IW=8, x[n] = n, out_ready = 1 -> fa_k = 2k+16, then fb_k = -16 for all k; first fa one cycle after x[16] is accepted.
REQ-037 Check the extreme-value scenario: x[0..15] = -128, x[16..31] = 127 -> fa = -1 and fb = -255, with no wrap in 9 bits.
REQ-038 Check backpressure: out_ready toggled randomly (50%) -> the output sequence is identical to REQ-036, data stays stable while stalled, and no sample is lost or duplicated.
REQ-039 Check back-to-back frames: two back-to-back frames with in_valid = 1 -> in_ready = 0 for exactly 16 DRAIN cycles per frame, and the second frame's results are correct.
REQ-040 Check reset mid-operation: rst_n pulsed low during CALC at cnt = 5 -> outputs are 0 immediately; a fresh frame then gives the REQ-036 results.
REQ-041 Check frame-start checking: with DFT_STAGE_SOF_CHK_EN, in_sof at FILL cnt = 7 -> frame_err = 1 and the frame restarting at that sample produces correct results.
